// File: rtl/vector3s_to_float.sv
// Serial converter from three signed Q12.20 components to IEEE-754 binary32 words.
// A single normalizer handles x, y, z in turn; the leading-zero search moves one bit per cycle.
module vector3s_to_float (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_point,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS   = 3'd1,
        S_SHIFT = 3'd2,
        S_PACK  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and both are registered.

    state_e      state_q;
    logic [95:0] point_q;
    logic [1:0]  comp_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [4:0]  lz_q;
    logic [31:0] out_x_q, out_y_q, out_z_q;
    logic        in_ready_q, out_valid_q;

    logic [31:0] cur_comp;
    logic [31:0] abs_mag;
    logic        round_up;
    logic [23:0] mant_r;
    logic [7:0]  exp_w;
    logic [31:0] pack_word;

    always_comb begin
        cur_comp = point_q[31:0];
        case (comp_q)
            2'd0:    cur_comp = point_q[95:64];
            2'd1:    cur_comp = point_q[63:32];
            default: cur_comp = point_q[31:0];
        endcase
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        abs_mag = cur_comp[31] ? (~cur_comp + 32'd1) : cur_comp;

        round_up  = mag_q[7] && ((|mag_q[6:0]) || mag_q[8]);
        mant_r    = {1'b0, mag_q[30:8]} + {23'd0, round_up};
        exp_w     = 8'd138 - {3'b000, lz_q} + {7'd0, mant_r[23]};
        pack_word = (mag_q == 32'd0) ? 32'd0 : {sign_q, exp_w, mant_r[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            point_q     <= 96'd0;
            comp_q      <= 2'd0;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            lz_q        <= 5'd0;
            out_x_q     <= 32'd0;
            out_y_q     <= 32'd0;
            out_z_q     <= 32'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        point_q    <= in_point;
                        comp_q     <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ABS;
                    end
                end
                S_ABS: begin
                    sign_q <= cur_comp[31];
                    mag_q  <= abs_mag;
                    lz_q   <= 5'd0;
                    // Already-normalized magnitudes skip SHIFT so it lasts exactly lz cycles.
                    if (abs_mag == 32'd0 || abs_mag[31]) begin
                        state_q <= S_PACK;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    mag_q <= {mag_q[30:0], 1'b0};
                    lz_q  <= lz_q + 5'd1;
                    if (mag_q[30]) begin
                        state_q <= S_PACK;
                    end
                end
                S_PACK: begin
                    case (comp_q)
                        2'd0:    out_x_q <= pack_word;
                        2'd1:    out_y_q <= pack_word;
                        default: out_z_q <= pack_word;
                    endcase
                    if (comp_q == 2'd2) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        comp_q  <= comp_q + 2'd1;
                        state_q <= S_ABS;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_z       = out_z_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vector3s_to_float.sv
// Directed-vector bench for vector3s_to_float: table of points with hand-computed
// binary32 results, plus backpressure, mid-conversion reset and a few random points.
module tb_vector3s_to_float;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_point;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x, out_y, out_z;
  logic [2:0]  dbg_state;

  int n_tests;
  int n_fail;

  vector3s_to_float dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_point    (in_point),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_z       (out_z),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, z;
    logic [31:0] ex, ey, ez;
  } vec_t;

  // scoreboard of expected words for the current point
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // leading zeros of |v| in 32 bits; 0 for a zero value
  function automatic int lz_of(input logic [31:0] v);
    longint m;
    int n;
    m = $signed(v);
    if (m < 0) m = -m;
    if (m == 0) return 0;
    n = 0;
    for (int b = 31; b >= 0; b--) begin
      if (m[b]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int lat_of(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return 6 + lz_of(x) + lz_of(y) + lz_of(z);
  endfunction

  // reference via the real value: double holds any Q12.20 exactly, then round to binary32
  function automatic logic [31:0] f32_model(input logic [31:0] v);
    real r;
    logic [63:0] b;
    logic [23:0] m;
    int e;
    if (v == 32'd0) return 32'd0;
    r = $itor($signed(v)) / 1048576.0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    m = {1'b0, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    return {b[63], e[7:0], m[22:0]};
  endfunction

  // driver: present a point on the falling edge, it is taken on the next rising edge
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    @(negedge clk);
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_point = {x, y, z};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_point = {$urandom, $urandom, $urandom};
  endtask

  // count rising edges after acceptance until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic run_point(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [31:0] ex, input logic [31:0] ey,
                           input logic [31:0] ez);
    int lat;
    exp_q.push_back(ex);
    exp_q.push_back(ey);
    exp_q.push_back(ez);
    send(x, y, z);
    wait_valid(lat);
    check({name, "_latency"}, lat, lat_of(x, y, z));
    check({name, "_x"}, out_x, exp_q.pop_front());
    check({name, "_y"}, out_y, exp_q.pop_front());
    check({name, "_z"}, out_z, exp_q.pop_front());
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[6];
  logic [31:0] hx, hy, hz;
  logic [31:0] rv[3];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_point  = 96'd0;
    out_ready = 1'b1;

    vecs[0] = '{32'h00100000, 32'hFFE80000, 32'h00000000, 32'h3F800000, 32'hBFC00000, 32'h00000000};
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'hC5000000, 32'h45000000, 32'h35800000};
    vecs[2] = '{32'h40000040, 32'h400000C0, 32'h40000041, 32'h44800000, 32'h44800002, 32'h44800001};
    vecs[3] = '{32'h00080000, 32'hFFF00000, 32'h00200000, 32'h3F000000, 32'hBF800000, 32'h40000000};
    vecs[4] = '{32'h80000001, 32'h00000003, 32'h01000000, 32'hC5000000, 32'h36400000, 32'h41800000};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_x", out_x, 32'd0);
    check("reset_out_y", out_y, 32'd0);
    check("reset_out_z", out_z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // the first vector must show out_valid exactly 28 cycles after acceptance
    check("first_vec_latency_const", lat_of(vecs[0].x, vecs[0].y, vecs[0].z), 32'd28);

    for (int i = 0; i < 6; i++) begin
      run_point($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].z,
                vecs[i].ex, vecs[i].ey, vecs[i].ez);
    end

    // backpressure: hold DONE for 10 cycles, stray in_valid pulses must be ignored
    begin
      int lat;
      out_ready = 1'b0;
      send(32'h00100000, 32'hFFE80000, 32'h00000000);
      wait_valid(lat);
      check("bp_latency", lat, 32'd28);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = i[0];
        in_point = {32'h00200000, 32'h00200000, 32'h00200000};
        @(posedge clk);
        #1;
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_x", out_x, 32'h3F800000);
        check("bp_out_y", out_y, 32'hBFC00000);
        check("bp_out_z", out_z, 32'h00000000);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      check("bp_no_phantom_point", {31'd0, out_valid}, 32'd0);
    end

    // reset in the middle of y's shift phase (x done after 13 cycles, y shifts from cycle 15)
    send(32'h00100000, 32'h00100000, 32'h00100000);
    repeat (18) @(posedge clk);
    #1;
    check("pre_reset_state_shift", {29'd0, dbg_state}, 32'd2);
    check("pre_reset_out_x", out_x, 32'h3F800000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_out_x", out_x, 32'd0);
    check("mid_reset_out_y", out_y, 32'd0);
    check("mid_reset_out_z", out_z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_point("after_reset", 32'h00100000, 32'h00100000, 32'h00100000,
              32'h3F800000, 32'h3F800000, 32'h3F800000);

    // random points against the real-valued reference
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        rv[k] = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) rv[k] = ~rv[k] + 32'd1;
      end
      hx = f32_model(rv[0]);
      hy = f32_model(rv[1]);
      hz = f32_model(rv[2]);
      run_point($sformatf("rand%0d", i), rv[0], rv[1], rv[2], hx, hy, hz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
